fb_addr_ctrl: RTL and testbench

Parametrised frame-buffer address controller for the video pipeline. It keeps an independent write pointer for the pixel producer (camera/processing side) and a read pointer for the display scanner. It supports single-buffer mode and ping-pong double-buffer mode, with a tear-free buffer swap at frame boundaries. It sits between the pixel source/sink handshakes and the SRAM arbiter, which consumes W_Address and R_Address directly.

---
 rtl/fb_addr_ctrl.sv | 117 +++++++++++
 tb/tb_fb_addr_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fb_addr_ctrl.sv
// Frame-buffer address controller: independent write/read pointers
// with single-buffer or ping-pong mode and tear-free frame-boundary swap.
module fb_addr_ctrl #(
  parameter int ADDR_W = 20,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mode,
  input  logic              W_Req,
  input  logic              R_Req,
  output logic              W_Ready,
  output logic [ADDR_W-1:0] W_Address,
  output logic [ADDR_W-1:0] R_Address,
  output logic [XW-1:0]     R_X,
  output logic [YW-1:0]     R_Y,
  output logic              W_Buf,
  output logic              R_Buf,
  output logic              W_Frame_Done,
  output logic              R_Frame_Done,
  output logic              Swap
);

  localparam int FRAME = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME);
  localparam logic [ADDR_W-1:0] W_LAST  = ADDR_W'(FRAME - 1);
  localparam logic [ADDR_W-1:0] H_A     = ADDR_W'(H_RES);
  localparam logic [XW-1:0]     X_LAST  = XW'(H_RES - 1);
  localparam logic [YW-1:0]     Y_LAST  = YW'(V_RES - 1);

  logic              mode_q;
  logic [ADDR_W-1:0] w_off_q, w_off_d;
  logic [XW-1:0]     r_x_q, r_x_d;
  logic [YW-1:0]     r_y_q, r_y_d;
  logic              w_buf_q, w_buf_d;
  logic              r_buf_q, r_buf_d;
  logic              pend_q, pend_d;
  logic              w_done_q, r_done_q, swap_q;

  logic w_acc, w_fin, r_fin, swap_now;

  assign w_acc    = W_Req & ~pend_q;
  assign w_fin    = w_acc & (w_off_q == W_LAST);
  assign r_fin    = R_Req & (r_x_q == X_LAST) & (r_y_q == Y_LAST);
  assign swap_now = mode_q & r_fin & (pend_q | w_fin);

  always_comb begin
    w_off_d = w_off_q;
    r_x_d   = r_x_q;
    r_y_d   = r_y_q;
    w_buf_d = w_buf_q;
    r_buf_d = r_buf_q;
    pend_d  = pend_q;
    if (w_acc) begin
      w_off_d = w_fin ? '0 : w_off_q + ADDR_W'(1);
    end
    if (R_Req) begin
      if (r_x_q == X_LAST) begin
        r_x_d = '0;
        r_y_d = (r_y_q == Y_LAST) ? '0 : r_y_q + YW'(1);
      end else begin
        r_x_d = r_x_q + XW'(1);
      end
    end
    // A same-cycle writer finish is consumed by the swap, never pended
    if (swap_now) begin
      w_buf_d = r_buf_q;
      r_buf_d = w_buf_q;
      pend_d  = 1'b0;
    end else if (mode_q & w_fin) begin
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q   <= Mode;
      w_off_q  <= '0;
      r_x_q    <= '0;
      r_y_q    <= '0;
      w_buf_q  <= 1'b0;
      r_buf_q  <= Mode;
      pend_q   <= 1'b0;
      w_done_q <= 1'b0;
      r_done_q <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      w_off_q  <= w_off_d;
      r_x_q    <= r_x_d;
      r_y_q    <= r_y_d;
      w_buf_q  <= w_buf_d;
      r_buf_q  <= r_buf_d;
      pend_q   <= pend_d;
      w_done_q <= w_fin;
      r_done_q <= r_fin;
      swap_q   <= swap_now;
    end
  end

  assign W_Ready      = ~pend_q;
  assign W_Buf        = w_buf_q;
  assign R_Buf        = r_buf_q;
  assign R_X          = r_x_q;
  assign R_Y          = r_y_q;
  assign W_Frame_Done = w_done_q;
  assign R_Frame_Done = r_done_q;
  assign Swap         = swap_q;

  assign W_Address = (w_buf_q ? FRAME_A : '0) + w_off_q;
  assign R_Address = (r_buf_q ? FRAME_A : '0)
                   + ADDR_W'(r_y_q) * H_A
                   + ADDR_W'(r_x_q);

endmodule

// File: tb/tb_fb_addr_ctrl.sv
// Directed bench for fb_addr_ctrl at H_RES=4, V_RES=2 (FRAME=8).
// Expected values are hand-derived from the frame geometry.
module tb_fb_addr_ctrl;

  localparam int AW = 20;

  logic          Clk = 1'b0;
  logic          Reset, Mode, W_Req, R_Req;
  logic          W_Ready, W_Buf, R_Buf;
  logic [AW-1:0] W_Address, R_Address;
  logic [1:0]    R_X;
  logic [0:0]    R_Y;
  logic          W_Frame_Done, R_Frame_Done, Swap;

  int n_vec = 0;
  int n_err = 0;

  fb_addr_ctrl #(.ADDR_W(AW), .H_RES(4), .V_RES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Mode(Mode),
    .W_Req(W_Req), .R_Req(R_Req), .W_Ready(W_Ready),
    .W_Address(W_Address), .R_Address(R_Address),
    .R_X(R_X), .R_Y(R_Y), .W_Buf(W_Buf), .R_Buf(R_Buf),
    .W_Frame_Done(W_Frame_Done), .R_Frame_Done(R_Frame_Done),
    .Swap(Swap)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic m);
    Reset = 1'b1; Mode = m; W_Req = 1'b0; R_Req = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic chk_pulses(input string tag, input logic wd,
                            input logic rd, input logic sw);
    chk({tag, ".wdone"}, 32'(W_Frame_Done), 32'(wd));
    chk({tag, ".rdone"}, 32'(R_Frame_Done), 32'(rd));
    chk({tag, ".swap"},  32'(Swap),         32'(sw));
  endtask

  initial begin
    Reset = 1'b1; Mode = 1'b0; W_Req = 1'b0; R_Req = 1'b0;

    // Reset in double mode
    do_reset(1'b1);
    chk("rst.waddr", 32'(W_Address), 32'd0);
    chk("rst.raddr", 32'(R_Address), 32'd8);
    chk("rst.wrdy",  32'(W_Ready),   32'd1);
    chk("rst.wbuf",  32'(W_Buf),     32'd0);
    chk("rst.rbuf",  32'(R_Buf),     32'd1);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);

    // Single mode, nine writes
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("sw.waddr", 32'(W_Address), 32'(i % 8));
      chk("sw.wrdy",  32'(W_Ready),   32'd1);
      W_Req = 1'b1;
      tick();
      chk_pulses("sw", (i == 7), 1'b0, 1'b0);
    end
    W_Req = 1'b0;
    chk("sw.waddr_end", 32'(W_Address), 32'd1);
    chk("sw.wbuf", 32'(W_Buf), 32'd0);

    // Single mode, five reads
    for (int i = 0; i < 5; i++) begin
      chk("sr.rx",    32'(R_X),       32'(i % 4));
      chk("sr.ry",    32'(R_Y),       32'(i / 4));
      chk("sr.raddr", 32'(R_Address), 32'(i));
      if (i < 4) begin
        R_Req = 1'b1;
        tick();
        R_Req = 1'b0;
      end
    end
    chk("sr.rbuf", 32'(R_Buf), 32'd0);

    // Double mode, writer finishes first then stalls
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("dw.waddr", 32'(W_Address), 32'(i));
      W_Req = 1'b1;
      tick();
    end
    chk_pulses("dw", 1'b1, 1'b0, 1'b0);
    chk("dw.wrdy",  32'(W_Ready),   32'd0);
    chk("dw.waddr", 32'(W_Address), 32'd0);
    tick();
    chk("dw.stall_wrdy",  32'(W_Ready),      32'd0);
    chk("dw.stall_waddr", 32'(W_Address),    32'd0);
    chk("dw.stall_wdone", 32'(W_Frame_Done), 32'd0);
    W_Req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("dr.raddr", 32'(R_Address), 32'(8 + i));
      R_Req = 1'b1;
      tick();
    end
    R_Req = 1'b0;
    chk_pulses("dr", 1'b0, 1'b1, 1'b1);
    chk("dr.wbuf",  32'(W_Buf),     32'd1);
    chk("dr.rbuf",  32'(R_Buf),     32'd0);
    chk("dr.wrdy",  32'(W_Ready),   32'd1);
    chk("dr.waddr", 32'(W_Address), 32'd8);
    chk("dr.raddr", 32'(R_Address), 32'd0);
    tick();
    chk_pulses("dr.after", 1'b0, 1'b0, 1'b0);

    // Double mode, simultaneous completion
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("sim.wrdy", 32'(W_Ready), 32'd1);
      W_Req = 1'b1; R_Req = 1'b1;
      tick();
    end
    W_Req = 1'b0; R_Req = 1'b0;
    chk_pulses("sim", 1'b1, 1'b1, 1'b1);
    chk("sim.wrdy",  32'(W_Ready),   32'd1);
    chk("sim.wbuf",  32'(W_Buf),     32'd1);
    chk("sim.rbuf",  32'(R_Buf),     32'd0);
    chk("sim.waddr", 32'(W_Address), 32'd8);
    chk("sim.raddr", 32'(R_Address), 32'd0);

    // Mid-frame reset with both requests high
    W_Req = 1'b1; R_Req = 1'b1;
    tick(); tick(); tick();
    chk("mid.waddr", 32'(W_Address), 32'd11);
    chk("mid.raddr", 32'(R_Address), 32'd3);
    Reset = 1'b1; Mode = 1'b1;
    tick();
    Reset = 1'b0; W_Req = 1'b0; R_Req = 1'b0;
    chk("mr.waddr", 32'(W_Address), 32'd0);
    chk("mr.raddr", 32'(R_Address), 32'd8);
    chk("mr.rx",    32'(R_X),       32'd0);
    chk("mr.ry",    32'(R_Y),       32'd0);
    chk("mr.wbuf",  32'(W_Buf),     32'd0);
    chk("mr.rbuf",  32'(R_Buf),     32'd1);
    chk("mr.wrdy",  32'(W_Ready),   32'd1);
    chk_pulses("mr", 1'b0, 1'b0, 1'b0);

    // Reader finishes with nothing pending: no swap, rescans
    Mode = 1'b0;
    R_Req = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    R_Req = 1'b0;
    chk_pulses("rescan", 1'b0, 1'b1, 1'b0);
    chk("rescan.rbuf",  32'(R_Buf),     32'd1);
    chk("rescan.raddr", 32'(R_Address), 32'd8);

    // Mode change outside reset is ignored: still double, so writer stalls
    W_Req = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    W_Req = 1'b0;
    chk("mode.wrdy", 32'(W_Ready), 32'd0);
    chk("mode.wdone", 32'(W_Frame_Done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
